operand_alu_harness: RTL and testbench
======================================

Name: operand_alu_harness

Overview:
Parametrised successor to the single-function test harness. Bytes are loaded into a two-operand buffer over an 8-bit bus, and a run-time-selected operation (NAND, ADD, SUB, ASR) executes under a start/busy/done handshake. Byte-wise operations run one byte per cycle with a carry chain held in a register. The result register is read back one byte at a time.
- Sits inside the TT top-level wrapper.
- The wrapper maps ui_in to din and maps uio_in bits to the select/strobe inputs.

Parameters:
LOG2_OP_BYTES, 2, log2 of operand size in bytes; OP_BYTES = 1<<LOG2_OP_BYTES; W = 8*OP_BYTES bits. Legal range 0..3.
SHW, derived localparam (not overridable) = LOG2_OP_BYTES+3, width of the shift amount.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  when low, the block ignores din_valid and start; in-flight ops still complete
din  in  8  write data byte
din_sel  in  LOG2_OP_BYTES+1  buffer byte index; 0..OP_BYTES-1 = X bytes (LSB first), OP_BYTES..2*OP_BYTES-1 = Y bytes
din_valid  in  1  write strobe, one byte per cycle
mode  in  2  0=NAND, 1=ADD, 2=SUB (X-Y), 3=ASR (X >>> Y[SHW-1:0])
start  in  1  launch request
busy  out  1  high while an op is running
done  out  1  one-cycle pulse when the result register updates
rd_sel  in  LOG2_OP_BYTES  result byte index
dout  out  8  result byte rd_sel, combinational mux of the result register

Behaviour:
- Reset, asynchronous and active-low: operand buffer=0, result=0, state=IDLE, busy=0, done=0, carry=0. Reset mid-RUN aborts the op; no done pulse is issued.
- Write: on a clk edge with din_valid&ena, buffer byte din_sel <= din. Writes are accepted in every state, so the next operands can load while an op runs.
- Start, accepted only in IDLE with ena:
  - Snapshots X, Y and mode into working registers.
  - A write in the same cycle lands in the buffer only; the snapshot takes the pre-write value.
  - start while busy is ignored.
- FSM:
  - IDLE -start-> RUN. busy=1 from the edge after start.
  - RUN, byte modes:
    - Byte index k runs 0..OP_BYTES-1, one per cycle.
    - Byte k of the result shadow = f(Xk, Yk, carry). carry updates per byte.
    - Initial carry: 1 for SUB (X + ~Y + 1), 0 otherwise.
    - After byte OP_BYTES-1 -> DONE.
  - RUN, ASR: single cycle, full-width arithmetic shift using the snapshot, -> DONE.
  - DONE, one cycle: result <= shadow (atomic; dout never shows a partial result), done=1, busy=0 in the same cycle, -> IDLE.
  - Latency from the start edge to the result-update edge: OP_BYTES+1 cycles for byte modes, 2 for ASR. A new start is accepted in the cycle done is high.
- NAND is bitwise ~(X&Y), full width.
- ASR: shift amount is Y[SHW-1:0] only; upper Y bits are ignored. Shift W-1 gives all sign bits.
- Arithmetic wraps mod 2^W.
- din_sel and rd_sel values out of range cannot occur at legal widths.

Optional Feature:
FLAGS_EN — when defined, adds outputs flag_c (1 bit) and flag_z (1 bit), both updated with the result register.
- flag_c:
  - ADD: final carry.
  - SUB: borrow, i.e. inverted final carry; 1 when X<Y unsigned.
  - NAND/ASR: 0.
- flag_z: result==0.
- Both flags reset to 0.
Without the macro the ports do not exist and there is no flag logic.

Decomposition:
Shared package operand_alu_pkg holds:
- mode enum (MODE_NAND, MODE_ADD, MODE_SUB, MODE_ASR)
- FSM state enum (ST_IDLE, ST_RUN, ST_DONE)
- helper function for W from LOG2_OP_BYTES
Sub-module alu_byte_slice is the natural split: 8-bit NAND/add/sub with carry in/out, instantiated once and time-multiplexed across byte index k.

Test Plan (LOG2_OP_BYTES=2, W=32):
- ADD: X=0x000000FF, Y=0x00000001, start -> busy 4 cycles, done on the 5th edge, result 0x00000100; dout bytes 00,01,00,00; flag_c=0.
- SUB: X=0, Y=1 -> result 0xFFFFFFFF; with FLAGS_EN, flag_c=1, flag_z=0. X=Y=0x12345678 -> result 0, flag_z=1, flag_c=0.
- ASR: X=0x80000000, Y=0xFFFFFFE4 (amount 4) -> result 0xF8000000 two edges after start. Amount 31 -> 0xFFFFFFFF.
- NAND: X=0xF0F0F0F0, Y=0xFF00FF00 -> result 0x0FFF0FFF.
- Overlap:
  - Writing a new Y during RUN leaves the current result unchanged.
  - start held high through done launches a second op with the new Y on the done cycle.
  - start during RUN is ignored.
  - Write and start in the same cycle snapshot the old value.
- Reset mid-op: assert rst_n=0 on the 2nd RUN cycle -> busy=0, result=0 immediately; no done pulse; buffer reads back 0.

Source files
------------

// File: rtl/operand_alu_pkg.sv
// Shared types for the operand ALU harness: operation modes, FSM states and
// the operand-width helper.
package operand_alu_pkg;

  typedef enum logic [1:0] {
    MODE_NAND = 2'd0,
    MODE_ADD  = 2'd1,
    MODE_SUB  = 2'd2,
    MODE_ASR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int op_width(input int log2_bytes);
    return 8 << log2_bytes;
  endfunction

endpackage

// File: rtl/alu_byte_slice.sv
// One byte of the NAND/ADD/SUB datapath with carry in/out; the top reuses it
// for every byte lane in turn.
module alu_byte_slice
  import operand_alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  mode_e      mode,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout
);

  logic [8:0] sum9;

  always_comb begin
    sum9 = '0;
    y    = '0;
    cout = 1'b0;
    case (mode)
      MODE_NAND: y = ~(a & b);
      MODE_ADD: begin
        sum9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        y    = sum9[7:0];
        cout = sum9[8];
      end
      // Subtraction as X + ~Y + carry; the top seeds carry with 1.
      MODE_SUB: begin
        sum9 = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
        y    = sum9[7:0];
        cout = sum9[8];
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/operand_alu_harness.sv
// Two-operand byte-loaded ALU harness with start/busy/done handshake.
// Optional FLAGS_EN adds carry/borrow and zero flags updated with the result.
module operand_alu_harness
  import operand_alu_pkg::*;
#(
  parameter int LOG2_OP_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               din,
  input  logic [LOG2_OP_BYTES:0]   din_sel,
  input  logic                     din_valid,
  input  logic [1:0]               mode,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [LOG2_OP_BYTES-1:0] rd_sel,
  output logic [7:0]               dout
`ifdef FLAGS_EN
  ,
  output logic                     flag_c,
  output logic                     flag_z
`endif
);

  localparam int OP_BYTES = 1 << LOG2_OP_BYTES;
  localparam int W        = op_width(LOG2_OP_BYTES);
  localparam int SHW      = LOG2_OP_BYTES + 3;
  localparam int KW       = (LOG2_OP_BYTES > 0) ? LOG2_OP_BYTES : 1;

  logic [7:0]    buf_reg [2*OP_BYTES];
  logic [W-1:0]  x_buf;
  logic [W-1:0]  y_buf;

  state_e        state_reg;
  mode_e         mode_reg;
  logic [W-1:0]  x_reg;
  logic [W-1:0]  y_reg;
  logic [W-1:0]  shadow_reg;
  logic [W-1:0]  result_reg;
  logic [KW-1:0] k_reg;
  logic          carry_reg;
  logic          busy_reg;
  logic          done_reg;

  logic [7:0]    x_byte;
  logic [7:0]    y_byte;
  logic [7:0]    slice_y;
  logic          slice_cout;
  logic [W-1:0]  lane_mask;
  logic [W-1:0]  shadow_next;
  logic [W-1:0]  asr_val;
  logic [7:0]    res_bytes [OP_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < OP_BYTES; gi++) begin : g_bytes
      assign x_buf[gi*8 +: 8] = buf_reg[gi];
      assign y_buf[gi*8 +: 8] = buf_reg[gi + OP_BYTES];
      assign res_bytes[gi]    = result_reg[gi*8 +: 8];
    end
  endgenerate

  assign dout = res_bytes[rd_sel];
  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2*OP_BYTES; i++) buf_reg[i] <= '0;
    end else if (din_valid && ena) begin
      buf_reg[din_sel] <= din;
    end
  end

  assign x_byte      = 8'(x_reg >> {k_reg, 3'b000});
  assign y_byte      = 8'(y_reg >> {k_reg, 3'b000});
  assign lane_mask   = W'(8'hFF) << {k_reg, 3'b000};
  assign shadow_next = (shadow_reg & ~lane_mask) | (W'(slice_y) << {k_reg, 3'b000});
  assign asr_val     = $signed(x_reg) >>> y_reg[SHW-1:0];

  alu_byte_slice u_slice (
    .a    (x_byte),
    .b    (y_byte),
    .mode (mode_reg),
    .cin  (carry_reg),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_NAND;
      x_reg      <= '0;
      y_reg      <= '0;
      shadow_reg <= '0;
      result_reg <= '0;
      k_reg      <= '0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Snapshot reads the buffer before any same-cycle write lands.
          if (start && ena) begin
            x_reg     <= x_buf;
            y_reg     <= y_buf;
            mode_reg  <= mode_e'(mode);
            carry_reg <= (mode == 2'(MODE_SUB));
            k_reg     <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mode_reg == MODE_ASR) begin
            shadow_reg <= asr_val;
            state_reg  <= ST_DONE;
          end else begin
            shadow_reg <= shadow_next;
            carry_reg  <= slice_cout;
            k_reg      <= k_reg + KW'(1);
            if (k_reg == KW'(OP_BYTES - 1)) state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          result_reg <= shadow_reg;
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef FLAGS_EN
  logic flag_c_reg;
  logic flag_z_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      flag_c_reg <= (mode_reg == MODE_ADD) ? carry_reg :
                    (mode_reg == MODE_SUB) ? ~carry_reg : 1'b0;
      flag_z_reg <= (shadow_reg == '0);
    end
  end

  assign flag_c = flag_c_reg;
  assign flag_z = flag_z_reg;
`endif

endmodule

// File: tb/tb_operand_alu_harness.sv
// Directed bench for operand_alu_harness at LOG2_OP_BYTES=2 (W=32); flag
// checks are included when FLAGS_EN is defined.
module tb_operand_alu_harness;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  din;
  logic [2:0]  din_sel;
  logic        din_valid;
  logic [1:0]  mode;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  rd_sel;
  logic [7:0]  dout;
`ifdef FLAGS_EN
  logic        flag_c;
  logic        flag_z;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] M_NAND = 2'd0;
  localparam logic [1:0] M_ADD  = 2'd1;
  localparam logic [1:0] M_SUB  = 2'd2;
  localparam logic [1:0] M_ASR  = 2'd3;

  always #10 clk = ~clk;

  operand_alu_harness #(.LOG2_OP_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .din       (din),
    .din_sel   (din_sel),
    .din_valid (din_valid),
    .mode      (mode),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_sel    (rd_sel),
    .dout      (dout)
`ifdef FLAGS_EN
    ,
    .flag_c    (flag_c),
    .flag_z    (flag_z)
`endif
  );

  task automatic load_op(input logic base, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din_sel   = {base, 2'(i)};
      din       = v[i*8 +: 8];
      din_valid = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic read_result(output logic [31:0] r);
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      r[i*8 +: 8] = dout;
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] m, output logic [31:0] r, output int lat);
    pulse_start(m);
    wait_done(0, lat);
    read_result(r);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    read_result(r);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL reset_result: got %h expected 00000000", r); end
    $display("reset: busy=%b done=%b result=%h", busy, done, r);
  endtask

  task automatic test_add;
    logic [31:0] r;
    logic [31:0] exp_r;
    logic [7:0]  exp_b;
    int lat;
    exp_r = 32'h00000100;
    load_op(1'b0, 32'h000000FF);
    load_op(1'b1, 32'h00000001);
    pulse_start(M_ADD);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
        begin n_err++; $display("FAIL add_busy_c%0d: got busy=%b done=%b expected 1/0", c, busy, done); end
    end
    rd_sel = 2'd1;
    #1;
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL add_no_partial: got %h expected 00", dout); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL add_done_edge5: got done=%b busy=%b expected 1/0", done, busy); end
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      exp_b = exp_r[i*8 +: 8];
      n_cmp++; if (dout !== exp_b) begin n_err++; $display("FAIL add_byte%0d: got %h expected %h", i, dout, exp_b); end
    end
`ifdef FLAGS_EN
    n_cmp++; if (flag_c !== 1'b0) begin n_err++; $display("FAIL add_flag_c: got %b expected 0", flag_c); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    $display("add: 000000ff+00000001 bytes checked");

    load_op(1'b0, 32'hFFFFFFFF);
    do_op(M_ADD, r, lat);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL add_wrap: got %h expected 00000000", r); end
`ifdef FLAGS_EN
    n_cmp++; if (flag_c !== 1'b1) begin n_err++; $display("FAIL add_wrap_flag_c: got %b expected 1", flag_c); end
`endif
    $display("add: ffffffff+00000001 -> %h lat=%0d", r, lat);
  endtask

  task automatic test_sub;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'h0);
    load_op(1'b1, 32'h1);
    do_op(M_SUB, r, lat);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL sub_0m1: got %h expected ffffffff", r); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL sub_latency: got %0d expected 5", lat); end
`ifdef FLAGS_EN
    n_cmp++; if (flag_c !== 1'b1 || flag_z !== 1'b0)
      begin n_err++; $display("FAIL sub_0m1_flags: got c=%b z=%b expected 1/0", flag_c, flag_z); end
`endif
    $display("sub: 0-1 -> %h lat=%0d", r, lat);
    load_op(1'b0, 32'h12345678);
    load_op(1'b1, 32'h12345678);
    do_op(M_SUB, r, lat);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL sub_equal: got %h expected 00000000", r); end
`ifdef FLAGS_EN
    n_cmp++; if (flag_c !== 1'b0 || flag_z !== 1'b1)
      begin n_err++; $display("FAIL sub_equal_flags: got c=%b z=%b expected 0/1", flag_c, flag_z); end
`endif
    $display("sub: 12345678-12345678 -> %h", r);
  endtask

  task automatic test_asr;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'h80000000);
    load_op(1'b1, 32'hFFFFFFE4);
    do_op(M_ASR, r, lat);
    n_cmp++; if (r !== 32'hF8000000) begin n_err++; $display("FAIL asr_4: got %h expected f8000000", r); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL asr_latency: got %0d expected 2", lat); end
    $display("asr: 80000000>>>4 -> %h lat=%0d", r, lat);
    load_op(1'b1, 32'h0000001F);
    do_op(M_ASR, r, lat);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL asr_31: got %h expected ffffffff", r); end
    $display("asr: 80000000>>>31 -> %h", r);
    load_op(1'b1, 32'h00000020);
    do_op(M_ASR, r, lat);
    n_cmp++; if (r !== 32'h80000000) begin n_err++; $display("FAIL asr_upper_ignored: got %h expected 80000000", r); end
    $display("asr: amount 0x20 (field 0) -> %h", r);
  endtask

  task automatic test_nand;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'hF0F0F0F0);
    load_op(1'b1, 32'hFF00FF00);
    do_op(M_NAND, r, lat);
    n_cmp++; if (r !== 32'h0FFF0FFF) begin n_err++; $display("FAIL nand: got %h expected 0fff0fff", r); end
`ifdef FLAGS_EN
    n_cmp++; if (flag_c !== 1'b0) begin n_err++; $display("FAIL nand_flag_c: got %b expected 0", flag_c); end
`endif
    $display("nand: f0f0f0f0,ff00ff00 -> %h lat=%0d", r, lat);
  endtask

  task automatic test_overlap_write;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'h1);
    load_op(1'b1, 32'h2);
    pulse_start(M_ADD);
    @(negedge clk);
    din_sel = 3'd4; din = 8'h10; din_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_done(1, lat);
    read_result(r);
    n_cmp++; if (r !== 32'h3) begin n_err++; $display("FAIL overlap_cur: got %h expected 00000003", r); end
    do_op(M_ADD, r, lat);
    n_cmp++; if (r !== 32'h11) begin n_err++; $display("FAIL overlap_next: got %h expected 00000011", r); end
    $display("overlap: write during run, next op -> %h", r);
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'h5);
    load_op(1'b1, 32'h3);
    @(negedge clk);
    mode = M_ADD; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    din_sel = 3'd4; din = 8'h07; din_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_done(1, lat);
    read_result(r);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 5", lat); end
    n_cmp++; if (r !== 32'h8) begin n_err++; $display("FAIL b2b_first: got %h expected 00000008", r); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_relaunch: got busy=%b expected 1", busy); end
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat);
    read_result(r);
    n_cmp++; if (lat !== 5 || r !== 32'hC)
      begin n_err++; $display("FAIL b2b_second: got %h lat=%0d expected 0000000c lat=5", r, lat); end
    $display("back_to_back: second result %h lat=%0d", r, lat);
  endtask

  task automatic test_write_start_same;
    logic [31:0] r;
    int lat;
    load_op(1'b0, 32'h10);
    load_op(1'b1, 32'h1);
    @(negedge clk);
    din_sel = 3'd0; din = 8'h20; din_valid = 1'b1; mode = M_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b0;
    wait_done(0, lat);
    read_result(r);
    n_cmp++; if (r !== 32'h11) begin n_err++; $display("FAIL same_cycle_snapshot: got %h expected 00000011", r); end
    do_op(M_ADD, r, lat);
    n_cmp++; if (r !== 32'h21) begin n_err++; $display("FAIL same_cycle_write: got %h expected 00000021", r); end
    $display("write+start: snapshot old, then %h", r);
  endtask

  task automatic test_reset_midop;
    logic [31:0] r;
    int lat;
    int done_seen;
    done_seen = 0;
    load_op(1'b0, 32'h11111111);
    load_op(1'b1, 32'h22222222);
    pulse_start(M_ADD);
    @(posedge clk); #1;
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    read_result(r);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL midrst_result: got %h expected 00000000", r); end
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (done) done_seen++; end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin @(posedge clk); #1; if (done) done_seen++; end
    n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
    do_op(M_NAND, r, lat);
    n_cmp++; if (r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL midrst_buffer: got %h expected ffffffff", r); end
    $display("reset mid-op: buffer nand -> %h", r);
  endtask

  task automatic test_ena;
    logic [31:0] r;
    int lat;
    ena = 1'b0;
    @(negedge clk);
    din_sel = 3'd0; din = 8'hAA; din_valid = 1'b1; mode = M_ADD; start = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ena_start_ignored: got busy=%b expected 0", busy); end
    @(negedge clk);
    din_valid = 1'b0; start = 1'b0; ena = 1'b1;
    do_op(M_ADD, r, lat);
    n_cmp++; if (r !== 32'h0) begin n_err++; $display("FAIL ena_write_ignored: got %h expected 00000000", r); end
    $display("ena low: write and start ignored, add -> %h", r);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; din = '0; din_sel = '0; din_valid = 1'b0;
    mode = '0; start = 1'b0; rd_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_add;
    test_sub;
    test_asr;
    test_nand;
    test_overlap_write;
    test_back_to_back;
    test_write_start_same;
    test_reset_midop;
    test_ena;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
